// File: rtl/regfile_ctrl_pkg.sv
// Shared widths, op codes and FSM state encoding for the regfile command sequencer.
// The CLR state exists only when REGFILE_CTRL_CLEAR_EN is defined.
package regfile_ctrl_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int REGNUM_W_DEF = 3;
  localparam int NUM_REGS_DEF = 2 ** REGNUM_W_DEF;

  typedef enum logic [2:0] {
    OP_MOV   = 3'd0,
    OP_SWAP  = 3'd1,
    OP_LOADI = 3'd2,
    OP_READ  = 3'd3,
    OP_CLEAR = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_S,
    S_RD_D,
    S_WR_D,
    S_WR_S,
    S_RSP
`ifdef REGFILE_CTRL_CLEAR_EN
    , S_CLR
`endif
  } state_e;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Command/response handshake bundle between a requester (master) and regfile_ctrl (slave).
interface regfile_ctrl_if
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REGNUM_W = REGNUM_W_DEF
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [REGNUM_W-1:0] cmd_rd;
  logic [REGNUM_W-1:0] cmd_rs;
  logic [DATA_W-1:0]   cmd_imm;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/regfile.sv
// 8x16 register file: one write port on posedge clk, one combinational read port.
module regfile #(
  parameter int DATA_W   = 16,
  parameter int REGNUM_W = 3
) (
  input  logic                clk,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [REGNUM_W-1:0] writenum,
  input  logic                write,
  input  logic [REGNUM_W-1:0] readnum,
  output logic [DATA_W-1:0]   data_out
);

  logic [DATA_W-1:0] regs [2**REGNUM_W];

  always_ff @(posedge clk) begin
    if (write) regs[writenum] <= data_in;
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/regfile_ctrl.sv
// Multi-cycle MOV/SWAP/LOADI/READ sequencer in front of the register file.
// Define REGFILE_CTRL_CLEAR_EN to add the CLEAR op (zeroes all registers).
//
// state  | meaning
// IDLE   | cmd_ready high, latch command on handshake
// RD_S   | read R[rs] into tmp_a
// RD_D   | read R[rd] into tmp_b (SWAP only)
// WR_D   | write R[rd] with imm (LOADI) or tmp_a
// WR_S   | write R[rs] with tmp_b (SWAP only)
// CLR    | write 0 to R[clr_cnt], clr_cnt 0..7
// RSP    | one-cycle response pulse
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REGNUM_W = REGNUM_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  regfile_ctrl_if.slave       bus,
  output logic [REGNUM_W-1:0] rf_readnum,
  input  logic [DATA_W-1:0]   rf_data_out,
  output logic [REGNUM_W-1:0] rf_writenum,
  output logic                rf_write,
  output logic [DATA_W-1:0]   rf_data_in
);

  state_e              state, state_nxt;
  logic [2:0]          op_q;
  logic [REGNUM_W-1:0] rd_q, rs_q;
  logic [DATA_W-1:0]   imm_q, tmp_a, tmp_b;
  logic                rsp_valid_q, rsp_err_q, rsp_err_nxt;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_nxt;
  logic                write_raw;
`ifdef REGFILE_CTRL_CLEAR_EN
  logic [REGNUM_W-1:0] clr_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
      tmp_a       <= '0;
      tmp_b       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
`ifdef REGFILE_CTRL_CLEAR_EN
      clr_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= (state_nxt == S_RSP);
      rsp_err_q   <= rsp_err_nxt;
      rsp_data_q  <= rsp_data_nxt;
      if (state == S_IDLE && bus.cmd_valid) begin
        op_q  <= bus.cmd_op;
        rd_q  <= bus.cmd_rd;
        rs_q  <= bus.cmd_rs;
        imm_q <= bus.cmd_imm;
      end
      if (state == S_RD_S) tmp_a <= rf_data_out;
      if (state == S_RD_D) tmp_b <= rf_data_out;
`ifdef REGFILE_CTRL_CLEAR_EN
      // wraps from all-ones back to 0 on the last CLR cycle
      if (state == S_CLR) clr_cnt <= clr_cnt + 1'b1;
      else                clr_cnt <= '0;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
    rf_readnum   = rs_q;
    rf_writenum  = rd_q;
    write_raw    = 1'b0;
    rf_data_in   = '0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_MOV, OP_SWAP, OP_READ: state_nxt = S_RD_S;
            OP_LOADI:                 state_nxt = S_WR_D;
`ifdef REGFILE_CTRL_CLEAR_EN
            OP_CLEAR:                 state_nxt = S_CLR;
`endif
            default: begin
              state_nxt   = S_RSP;
              rsp_err_nxt = 1'b1;
            end
          endcase
        end
      end
      S_RD_S: begin
        case (op_q)
          OP_SWAP: state_nxt = S_RD_D;
          OP_MOV:  state_nxt = S_WR_D;
          default: begin
            state_nxt    = S_RSP;
            rsp_data_nxt = rf_data_out;
          end
        endcase
      end
      S_RD_D: begin
        rf_readnum = rd_q;
        state_nxt  = S_WR_D;
      end
      S_WR_D: begin
        write_raw  = 1'b1;
        rf_data_in = (op_q == OP_LOADI) ? imm_q : tmp_a;
        if (op_q == OP_SWAP) begin
          state_nxt = S_WR_S;
        end else begin
          state_nxt    = S_RSP;
          rsp_data_nxt = rf_data_in;
        end
      end
      S_WR_S: begin
        rf_writenum  = rs_q;
        write_raw    = 1'b1;
        rf_data_in   = tmp_b;
        state_nxt    = S_RSP;
        rsp_data_nxt = tmp_b;
      end
`ifdef REGFILE_CTRL_CLEAR_EN
      S_CLR: begin
        rf_writenum = clr_cnt;
        write_raw   = 1'b1;
        if (clr_cnt == '1) state_nxt = S_RSP;
      end
`endif
      S_RSP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // a reset edge must never commit a half-finished write
  assign rf_write      = write_raw & ~reset;
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl + regfile against an array-based register model.
module tb_regfile_ctrl;
  import regfile_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] rf_readnum, rf_writenum;
  logic [DW-1:0] rf_data_out, rf_data_in;
  logic          rf_write;

  regfile_ctrl_if #(.DATA_W(DW), .REGNUM_W(RW)) bus ();

  regfile_ctrl #(.DATA_W(DW), .REGNUM_W(RW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in)
  );

  regfile #(.DATA_W(DW), .REGNUM_W(RW)) u_rf (
    .clk(clk), .data_in(rf_data_in), .writenum(rf_writenum), .write(rf_write),
    .readnum(rf_readnum), .data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdl [8];
  int          wr_num_q [$];
  logic [15:0] wr_dat_q [$];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command from IDLE and returns latency (0 = none within budget) and response.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [15:0] imm, output int lat, output logic [15:0] data,
                         output logic err, output int nwr);
    wr_num_q.delete();
    wr_dat_q.delete();
    lat  = 0;
    data = 'x;
    err  = 1'bx;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs    = rs;
    bus.cmd_imm   = imm;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_rd    = 3'($urandom);
    bus.cmd_rs    = 3'($urandom);
    bus.cmd_imm   = 16'($urandom);
    for (int k = 1; k <= 20; k++) begin
      if (rf_write) begin
        wr_num_q.push_back(int'(rf_writenum));
        wr_dat_q.push_back(rf_data_in);
      end
      if (bus.rsp_valid) begin
        lat  = k;
        data = bus.rsp_data;
        err  = bus.rsp_err;
        break;
      end
      tick();
    end
    nwr = wr_num_q.size();
    tick();
  endtask

  // Reference: what each op does to the register array and what it answers.
  function automatic void model_exec(input int op, input int rd, input int rs, input logic [15:0] imm,
                                     output int lat, output logic [15:0] data, output logic err,
                                     output int nwr);
    logic [15:0] t;
    err  = 1'b0;
    data = 16'h0;
    case (op)
      0: begin data = mdl[rs]; mdl[rd] = mdl[rs]; lat = 3; nwr = 1; end
      1: begin data = mdl[rd]; t = mdl[rd]; mdl[rd] = mdl[rs]; mdl[rs] = t; lat = 5; nwr = 2; end
      2: begin data = imm; mdl[rd] = imm; lat = 2; nwr = 1; end
      3: begin data = mdl[rs]; lat = 2; nwr = 0; end
`ifdef REGFILE_CTRL_CLEAR_EN
      4: begin for (int i = 0; i < 8; i++) mdl[i] = 16'h0; lat = 9; nwr = 8; end
`endif
      default: begin err = 1'b1; lat = 1; nwr = 0; end
    endcase
  endfunction

  task automatic test_reset();
    int lat, elat, nwr, enwr;
    logic [15:0] d, ed;
    logic e, ee;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs = '0; bus.cmd_imm = '0;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
    checks++; if (bus.rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0000", bus.rsp_data); end
    checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL reset_rf_write: got %b expected 0", rf_write); end
    reset = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      model_exec(2, i, 0, v, elat, ed, ee, enwr);
      run_cmd(3'd2, 3'(i), 3'd0, v, lat, d, e, nwr);
      checks++; if (lat !== elat || d !== ed) begin errors++; $display("FAIL preload_R%0d: got lat %0d data %h expected lat %0d data %h", i, lat, d, elat, ed); end
    end
  endtask

  task automatic test_loadi_read();
    int lat, elat, nwr, enwr;
    logic [15:0] d, ed;
    logic e, ee;
    model_exec(2, 3, 0, 16'h00A5, elat, ed, ee, enwr);
    run_cmd(3'd2, 3'd3, 3'd0, 16'h00A5, lat, d, e, nwr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL loadi_latency: got %0d expected 2", lat); end
    checks++; if (d !== 16'h00A5 || e !== 1'b0) begin errors++; $display("FAIL loadi_rsp: got %h err %b expected 00a5 err 0", d, e); end
    model_exec(3, 0, 3, 16'h0, elat, ed, ee, enwr);
    run_cmd(3'd3, 3'd0, 3'd3, 16'h0, lat, d, e, nwr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d expected 2", lat); end
    checks++; if (d !== 16'h00A5) begin errors++; $display("FAIL read_data: got %h expected 00a5", d); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL read_writes: got %0d expected 0", nwr); end
  endtask

  task automatic test_swap();
    int lat, elat, nwr, enwr;
    logic [15:0] d, ed;
    logic e, ee;
    model_exec(2, 1, 0, 16'h1234, elat, ed, ee, enwr);
    run_cmd(3'd2, 3'd1, 3'd0, 16'h1234, lat, d, e, nwr);
    model_exec(2, 6, 0, 16'hBEEF, elat, ed, ee, enwr);
    run_cmd(3'd2, 3'd6, 3'd0, 16'hBEEF, lat, d, e, nwr);
    model_exec(1, 6, 1, 16'h0, elat, ed, ee, enwr);
    run_cmd(3'd1, 3'd6, 3'd1, 16'h0, lat, d, e, nwr);
    checks++; if (lat !== 5) begin errors++; $display("FAIL swap_latency: got %0d expected 5", lat); end
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL swap_rsp_data: got %h expected beef", d); end
    checks++; if (nwr !== 2) begin errors++; $display("FAIL swap_writes: got %0d expected 2", nwr); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (u_rf.regs[i] !== mdl[i]) begin errors++; $display("FAIL swap_R%0d: got %h expected %h", i, u_rf.regs[i], mdl[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, elat, nwr, enwr;
    logic [15:0] d, ed, rd_exp;
    logic e, ee;
    model_exec(2, 2, 0, 16'h0F0F, elat, ed, ee, enwr);
    run_cmd(3'd2, 3'd2, 3'd0, 16'h0F0F, lat, d, e, nwr);
    model_exec(0, 2, 2, 16'h0, elat, ed, ee, enwr);
    model_exec(3, 0, 6, 16'h0, elat, rd_exp, ee, enwr);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd0; bus.cmd_rd = 3'd2; bus.cmd_rs = 3'd2; bus.cmd_imm = 16'h0;
    tick();
    bus.cmd_op = 3'd3; bus.cmd_rd = 3'd0; bus.cmd_rs = 3'd6;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_N+%0d: got %b expected 0", k, bus.cmd_ready); end
      if (k == 3) begin
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0F0F) begin errors++; $display("FAIL b2b_mov_rsp: got valid %b data %h expected valid 1 data 0f0f", bus.rsp_valid, bus.rsp_data); end
      end
      tick();
    end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_N+4: got %b expected 1", bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.rsp_valid) begin lat = k; d = bus.rsp_data; break; end
      tick();
    end
    tick();
    checks++; if (lat !== 2 || d !== rd_exp) begin errors++; $display("FAIL b2b_read: got lat %0d data %h expected lat 2 data %h", lat, d, rd_exp); end
    checks++; if (u_rf.regs[2] !== 16'h0F0F) begin errors++; $display("FAIL mov_same_R2: got %h expected 0f0f", u_rf.regs[2]); end
  endtask

  task automatic test_illegal();
    int lat, elat, nwr, enwr;
    logic [15:0] d, ed;
    logic e, ee;
    for (int op = 5; op <= 7; op++) begin
      model_exec(op, 1, 2, 16'hFFFF, elat, ed, ee, enwr);
      run_cmd(3'(op), 3'd1, 3'd2, 16'hFFFF, lat, d, e, nwr);
      checks++; if (lat !== 1 || e !== 1'b1 || d !== 16'h0 || nwr !== 0) begin
        errors++; $display("FAIL illegal_op%0d: got lat %0d err %b data %h writes %0d expected lat 1 err 1 data 0000 writes 0", op, lat, e, d, nwr);
      end
    end
  endtask

  task automatic test_op4();
    int lat, elat, nwr, enwr;
    logic [15:0] d, ed;
    logic e, ee;
    for (int i = 0; i < 8; i++) begin
      model_exec(2, i, 0, 16'hFFFF, elat, ed, ee, enwr);
      run_cmd(3'd2, 3'(i), 3'd0, 16'hFFFF, lat, d, e, nwr);
    end
    model_exec(4, 0, 0, 16'h0, elat, ed, ee, enwr);
    run_cmd(3'd4, 3'd0, 3'd0, 16'h0, lat, d, e, nwr);
    checks++; if (lat !== elat || e !== ee || d !== 16'h0 || nwr !== enwr) begin
      errors++; $display("FAIL op4: got lat %0d err %b data %h writes %0d expected lat %0d err %b data 0000 writes %0d", lat, e, d, nwr, elat, ee, enwr);
    end
`ifdef REGFILE_CTRL_CLEAR_EN
    for (int i = 0; i < wr_num_q.size(); i++) begin
      checks++; if (wr_num_q[i] !== i || wr_dat_q[i] !== 16'h0) begin errors++; $display("FAIL clear_write%0d: got reg %0d data %h expected reg %0d data 0000", i, wr_num_q[i], wr_dat_q[i], i); end
    end
`endif
    for (int i = 0; i < 8; i++) begin
      checks++; if (u_rf.regs[i] !== mdl[i]) begin errors++; $display("FAIL op4_R%0d: got %h expected %h", i, u_rf.regs[i], mdl[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, elat, nwr, enwr;
    logic [15:0] d, ed;
    logic e, ee;
    model_exec(2, 0, 0, 16'hAAAA, elat, ed, ee, enwr);
    run_cmd(3'd2, 3'd0, 3'd0, 16'hAAAA, lat, d, e, nwr);
    model_exec(2, 5, 0, 16'h5555, elat, ed, ee, enwr);
    run_cmd(3'd2, 3'd5, 3'd0, 16'h5555, lat, d, e, nwr);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd1; bus.cmd_rd = 3'd0; bus.cmd_rs = 3'd5;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL abort_rf_write: got %b expected 0", rf_write); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.cmd_ready); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid_%0d: got %b expected 0", k, bus.rsp_valid); end
      tick();
    end
    checks++; if (u_rf.regs[0] !== 16'hAAAA || u_rf.regs[5] !== 16'h5555) begin
      errors++; $display("FAIL abort_regs: got R0 %h R5 %h expected R0 aaaa R5 5555", u_rf.regs[0], u_rf.regs[5]);
    end
  endtask

  task automatic test_random();
    int lat, elat, nwr, enwr, op, rd, rs;
    logic [15:0] d, ed, imm;
    logic e, ee;
    for (int n = 0; n < 80; n++) begin
      op  = $urandom_range(0, 7);
      rd  = $urandom_range(0, 7);
      rs  = $urandom_range(0, 7);
      imm = 16'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      model_exec(op, rd, rs, imm, elat, ed, ee, enwr);
      run_cmd(3'(op), 3'(rd), 3'(rs), imm, lat, d, e, nwr);
      checks++; if (lat !== elat || d !== ed || e !== ee || nwr !== enwr) begin
        errors++; $display("FAIL rand%0d_op%0d: got lat %0d data %h err %b writes %0d expected lat %0d data %h err %b writes %0d", n, op, lat, d, e, nwr, elat, ed, ee, enwr);
      end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_pulse: got rsp_valid %b after RSP expected 0", n, bus.rsp_valid); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (u_rf.regs[i] !== mdl[i]) begin errors++; $display("FAIL rand_R%0d: got %h expected %h", i, u_rf.regs[i], mdl[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_loadi_read();
    test_swap();
    test_back_to_back();
    test_illegal();
    test_op4();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Multi-cycle command sequencer in front of the 8x16 register file (single write port, single combinational read port, write on posedge clk).
- Accepts one register-level command at a time (MOV, SWAP, LOADI, READ, optional CLEAR) over a valid/ready handshake.
- Drives the regfile's readnum/writenum/write/data_in and returns a single-cycle response.
- Sits between the CPU control FSM or a debug port and the regfile.

Parameters:
- DATA_W, 16, register width; must match regfile data width.
- REGNUM_W, 3, register index width; NUM_REGS = 2**REGNUM_W = 8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  0 MOV, 1 SWAP, 2 LOADI, 3 READ, 4 CLEAR (optional), 5-7 illegal.
- cmd_rd  in  REGNUM_W  destination register.
- cmd_rs  in  REGNUM_W  source register.
- cmd_imm  in  DATA_W  immediate for LOADI.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_data  out  DATA_W  result; valid only with rsp_valid.
- rsp_err  out  1  illegal-op flag; valid only with rsp_valid.
- rf_readnum  out  REGNUM_W  to regfile readnum.
- rf_data_out  in  DATA_W  from regfile data_out (combinational).
- rf_writenum  out  REGNUM_W  to regfile writenum.
- rf_write  out  1  to regfile write.
- rf_data_in  out  DATA_W  to regfile data_in.

Behaviour:
- Clock and reset: clk, reset; reset is synchronous, active-high. Reset forces IDLE, rsp_valid=0, rsp_err=0, rsp_data=0, tmp_a=tmp_b=0, clr_cnt=0. cmd_ready=1 in the first cycle after reset.
- rf_write is gated with !reset, so no regfile write occurs on a reset edge. Regfile contents are not cleared by reset.
- Accept: handshake when cmd_valid && cmd_ready in IDLE. op, rd, rs and imm are latched at that edge; later changes on cmd_* are ignored.
- States: IDLE, RD_S, RD_D, WR_D, WR_S, CLR, RSP.
- RD_S: rf_readnum=rs; tmp_a <= rf_data_out.
- RD_D: rf_readnum=rd; tmp_b <= rf_data_out.
- WR_D: rf_writenum=rd; rf_write=1; rf_data_in = imm for LOADI, else tmp_a.
- WR_S: rf_writenum=rs; rf_write=1; rf_data_in=tmp_b.
- Sequences (N = accept cycle; rsp_valid cycle in brackets):
  - MOV: RD_S, WR_D, RSP; rsp_data=old R[rs] [N+3].
  - SWAP: RD_S, RD_D, WR_D, WR_S, RSP; rsp_data=old R[rd] [N+5].
  - LOADI: WR_D, RSP; rsp_data=imm [N+2].
  - READ: RD_S, RSP; rsp_data=R[rs] [N+2].
  - Illegal op: RSP only; rsp_err=1, rsp_data=0, no regfile write [N+1].
- RSP always returns to IDLE. The earliest next accept is the cycle after RSP.
- Outside write states: rf_write=0, rf_data_in=0, rf_writenum=rd. rf_readnum=rs except in RD_D.
- rd==rs: MOV and SWAP still execute the full sequence; the net register value is unchanged.
- Reset mid-operation: abort immediately. A partially done SWAP may leave R[rd] updated and R[rs] not; this is accepted. No rsp_valid for the aborted command.

Optional Feature:
- Macro REGFILE_CTRL_CLEAR_EN.
- Defined: op 4 CLEAR enters CLR for 8 cycles with clr_cnt 0..7. Each CLR cycle drives rf_writenum=clr_cnt, rf_write=1, rf_data_in=0. After clr_cnt==7 go to RSP; rsp_data=0, rsp_err=0 [N+9]. clr_cnt resets to 0 on leaving CLR.
- Undefined: op 4 is illegal (rsp_err=1, N+1), and no CLR state or counter logic is compiled.

Decomposition:
- Package regfile_ctrl_pkg: DATA_W/REGNUM_W defaults; op enum (OP_MOV, OP_SWAP, OP_LOADI, OP_READ, OP_CLEAR); state enum.
- Single module with no sub-module; the FSM, temp registers and counter are small enough to stay flat.
- Bench instantiates regfile_ctrl together with the existing regfile.

Test Plan:
- Reset, then LOADI rd=3 imm=16'h00A5 -> rsp_valid at N+2, rsp_data=16'h00A5; a following READ rs=3 returns 16'h00A5 at N+2.
- R1=16'h1234, R6=16'hBEEF; SWAP rd=6 rs=1 -> rsp at N+5, rsp_data=16'hBEEF; then R6=16'h1234, R1=16'hBEEF; no other register changes.
- MOV rd=2 rs=2 with R2=16'h0F0F -> rsp_data=16'h0F0F at N+3; R2 unchanged. Also check cmd_ready=0 from N+1 to N+3 while cmd_valid stays high with a different op; that command is accepted only at N+4.
- cmd_op=7 -> rsp_valid and rsp_err=1 at N+1, rsp_data=0, rf_write never asserted.
- Start SWAP rd=0 rs=5, assert reset in the WR_D cycle -> rf_write=0 that cycle; R0 and R5 keep their old values; IDLE with cmd_ready=1 next cycle; no rsp_valid.
- With REGFILE_CTRL_CLEAR_EN: preload all registers to 16'hFFFF, issue CLEAR -> 8 consecutive writes to regs 0..7, rsp at N+9, all registers read back 0. Without the macro: op 4 -> rsp_err=1 at N+1 and registers are unchanged.
